// File: rtl/aes128_key_sched_seq.sv
// Iterative AES-128 key schedule: round key 0 one cycle after key_load, keys 1..10 one per rk_valid&rk_ready, held while stalled.
// Define AES_KEY_SCHED_LAST_KEY_EN to add last_key/last_key_valid, a capture of round key 10.

// Byte-wise AES S-box over a 128-bit word, purely combinational.
module sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  // Byte 0x00 sits in the top byte; 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = SBOX_TBL[{~data_i[8*i +: 8], 3'b111} -: 8];
  end

endmodule

module aes128_key_sched_seq #(
  parameter int ROUND_IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_load,
  input  logic [127:0]           key_in,
  input  logic                   rk_ready,
  output logic                   rk_valid,
  output logic [127:0]           round_key,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic                   busy,
  output logic                   done
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  ,
  output logic [127:0]           last_key,
  output logic                   last_key_valid
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic [127:0] key_q;
  logic [127:0] key_d;
  logic [3:0]   idx_q;
  logic         vld_q;
  logic         busy_q;
  logic         done_q;
  logic [7:0]   rcon;
  logic [127:0] sb_in;
  logic [127:0] sb_out;
  logic [95:0]  sb_out_unused;
  logic [31:0]  t_word;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;

  // Rcon for the key being produced next, i.e. Rcon[idx_q + 1].
  always_comb begin
    rcon = 8'h00;
    case (idx_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign sb_in = {key_q[23:0], key_q[31:24], 96'b0};

  sub_bytes u_sub_bytes (
    .data_i (sb_in),
    .data_o (sb_out)
  );

  assign sb_out_unused = sb_out[95:0];
  assign t_word        = sb_out[127:96] ^ {rcon, 24'h0};
  assign w0_n          = key_q[127:96] ^ t_word;
  assign w1_n          = key_q[95:64]  ^ w0_n;
  assign w2_n          = key_q[63:32]  ^ w1_n;
  assign w3_n          = key_q[31:0]   ^ w2_n;
  assign key_d         = {w0_n, w1_n, w2_n, w3_n};

`ifdef AES_KEY_SCHED_LAST_KEY_EN
  logic [127:0] last_key_q;
  logic         last_vld_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
      last_key_q <= '0;
      last_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_load) begin
            state_q <= RUN;
            key_q   <= key_in;
            idx_q   <= '0;
            vld_q   <= 1'b1;
            busy_q  <= 1'b1;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
            last_key_q <= '0;
            last_vld_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (vld_q && rk_ready) begin
            if (idx_q == 4'd10) begin
              state_q <= IDLE;
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
              last_key_q <= key_q;
              last_vld_q <= 1'b1;
`endif
            end else begin
              key_q <= key_d;
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_valid  = vld_q;
  assign round_key = key_q;
  assign round_idx = ROUND_IDX_W'(idx_q);
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  assign last_key       = last_key_q;
  assign last_key_valid = last_vld_q;
`endif

endmodule

// File: tb/tb_aes128_key_sched_seq.sv
// Directed bench for aes128_key_sched_seq using the FIPS-197 key expansion vectors.
module tb_aes128_key_sched_seq;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  logic [127:0] last_key;
  logic         last_key_valid;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] fips_rk [0:10];

  aes128_key_sched_seq #(.ROUND_IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    ,
    .last_key       (last_key),
    .last_key_valid (last_key_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n = 0;
    while (!(rk_valid === 1'b1 && round_idx === target) && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!(rk_valid === 1'b1 && round_idx === target)) begin
      errors++;
      $display("FAIL wait_idx timeout: idx=%0d valid=%b, required idx=%0d valid=1", round_idx, rk_valid, target);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done timeout: done=%b, required 1", done);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; key_in = '1;
    tick();
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    checks++;
    if ({rk_valid, busy, done} !== 3'b000 || round_key !== 128'h0 || round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset: v/b/d=%b key=%h idx=%0d, required 000 key=0 idx=0", {rk_valid, busy, done}, round_key, round_idx);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({rk_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: v/b/d=%b, required 000", {rk_valid, busy, done});
    end
  endtask

  task automatic test_fips();
    rk_ready = 1'b1;
    key_in   = FIPS_KEY;
    key_load = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      tick();
      key_load = 1'b0;
      checks++;
      if (n <= 11) begin
        if (round_key !== fips_rk[n-1] || round_idx !== 4'(n-1) || {rk_valid, busy, done} !== 3'b110) begin
          errors++;
          $display("FAIL fips_rk%0d: key=%h idx=%0d v/b/d=%b, required key=%h idx=%0d v/b/d=110",
                   n-1, round_key, round_idx, {rk_valid, busy, done}, fips_rk[n-1], n-1);
        end
      end else if (n == 12) begin
        if ({rk_valid, busy, done} !== 3'b001 || round_key !== fips_rk[10]) begin
          errors++;
          $display("FAIL fips_done: v/b/d=%b key=%h, required v/b/d=001 key=%h", {rk_valid, busy, done}, round_key, fips_rk[10]);
        end
      end else begin
        if ({rk_valid, busy, done} !== 3'b000) begin
          errors++;
          $display("FAIL fips_done_pulse: v/b/d=%b, required 000", {rk_valid, busy, done});
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    wait_idx(4'd3);
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (round_key !== fips_rk[3] || round_idx !== 4'd3 || rk_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d: key=%h idx=%0d v=%b, required key=%h idx=3 v=1", i, round_key, round_idx, rk_valid, fips_rk[3]);
      end
    end
    rk_ready = 1'b1;
    for (int k = 4; k <= 10; k++) begin
      tick();
      checks++;
      if (round_key !== fips_rk[k] || round_idx !== 4'(k)) begin
        errors++;
        $display("FAIL resume_rk%0d: key=%h idx=%0d, required key=%h idx=%0d", k, round_key, round_idx, fips_rk[k], k);
      end
    end
    wait_done();
  endtask

  task automatic test_load_ignored();
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    wait_idx(4'd5);
    key_load = 1'b1;
    key_in   = 128'h0;
    tick();
    key_load = 1'b0;
    for (int k = 6; k <= 10; k++) begin
      checks++;
      if (round_key !== fips_rk[k] || round_idx !== 4'(k) || rk_valid !== 1'b1) begin
        errors++;
        $display("FAIL busy_load_rk%0d: key=%h idx=%0d, required key=%h idx=%0d", k, round_key, round_idx, fips_rk[k], k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_load_done: done=%b v=%b, required done=1 v=0", done, rk_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    wait_idx(4'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({rk_valid, busy, done} !== 3'b000 || round_key !== 128'h0 || round_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: v/b/d=%b key=%h idx=%0d, required 000 key=0 idx=0", {rk_valid, busy, done}, round_key, round_idx);
    end
    tick();
    checks++;
    if (rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stays_idle: v=%b, required 0", rk_valid);
    end
    start_key(128'h0);
    checks++;
    if (round_key !== 128'h0 || round_idx !== 4'd0 || rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_rk0: key=%h idx=%0d v=%b, required key=0 idx=0 v=1", round_key, round_idx, rk_valid);
    end
    tick();
    checks++;
    if (round_key !== ZERO_R1 || round_idx !== 4'd1) begin
      errors++;
      $display("FAIL zero_rk1: key=%h idx=%0d, required key=%h idx=1", round_key, round_idx, ZERO_R1);
    end
    wait_done();
  endtask

  task automatic test_load_at_last();
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    wait_idx(4'd10);
    key_load = 1'b1;
    key_in   = 128'h0;
    tick();
    checks++;
    if ({rk_valid, busy, done} !== 3'b001 || round_key !== fips_rk[10]) begin
      errors++;
      $display("FAIL load_at_last: v/b/d=%b key=%h, required 001 key=%h", {rk_valid, busy, done}, round_key, fips_rk[10]);
    end
    tick();
    key_load = 1'b0;
    checks++;
    if ({rk_valid, busy, done} !== 3'b110 || round_key !== 128'h0 || round_idx !== 4'd0) begin
      errors++;
      $display("FAIL load_after_done: v/b/d=%b key=%h idx=%0d, required 110 key=0 idx=0", {rk_valid, busy, done}, round_key, round_idx);
    end
    tick();
    checks++;
    if (round_key !== ZERO_R1 || round_idx !== 4'd1) begin
      errors++;
      $display("FAIL load_after_done_rk1: key=%h idx=%0d, required key=%h idx=1", round_key, round_idx, ZERO_R1);
    end
    wait_done();
  endtask

`ifdef AES_KEY_SCHED_LAST_KEY_EN
  task automatic test_last_key();
    rk_ready = 1'b1;
    start_key(FIPS_KEY);
    wait_done();
    checks++;
    if (last_key !== fips_rk[10] || last_key_valid !== 1'b1) begin
      errors++;
      $display("FAIL last_key: key=%h v=%b, required key=%h v=1", last_key, last_key_valid, fips_rk[10]);
    end
    start_key(128'h0);
    checks++;
    if (last_key !== 128'h0 || last_key_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_key_clear: key=%h v=%b, required key=0 v=0", last_key, last_key_valid);
    end
    wait_done();
  endtask
`endif

  initial begin
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips();
    test_backpressure();
    test_load_ignored();
    test_reset_mid();
    test_load_at_last();
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    test_last_key();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
